// File: rtl/rdma_unpacker.sv
// ---------------------------------------------------------------------------
// rdma_unpacker
//   Receive side of the RDMA header packer. It takes a 4-beat, 32-bit,
//   byte-reversed header stream and reassembles it into
//   src_address / dst_address / operation / counter.
//   The fields are presented on a valid/ready result port. Malformed frames
//   (short, long, partial keep) produce a single error pulse. Frames that
//   are delivered and frames that are errored are counted in saturating
//   counters.
//
// Optional feature (compile-time macro RDMA_SEQ_CHECK_EN):
//   Adds output err_seq. It pulses with the rising edge of result_valid
//   when a good frame's counter is not the previous good counter + 1
//   (mod 2^31). The first good frame after reset is never flagged.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   data_slave/keep_slave/valid_slave/last_slave/ready_slave
//                                 header stream in (wire byte order reversed)
//   src_address, dst_address, operation, counter
//                                 recovered fields, stable while result_valid
//   result_valid / result_ready   result handshake
//   err_short, err_long, err_keep 1-cycle error pulses, one per bad frame
//   frame_count, err_count        saturating CNT_W-bit counters
//   err_seq                       (RDMA_SEQ_CHECK_EN only) sequence gap pulse
// ---------------------------------------------------------------------------
module rdma_unpacker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_slave,
  input  logic [3:0]       keep_slave,
  input  logic             valid_slave,
  input  logic             last_slave,
  output logic             ready_slave,
  output logic [47:0]      src_address,
  output logic [47:0]      dst_address,
  output logic             operation,
  output logic [30:0]      counter,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             err_short,
  output logic             err_long,
  output logic             err_keep,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
`ifdef RDMA_SEQ_CHECK_EN
  ,
  output logic             err_seq
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        keep_bad, keep_bad_nxt;
  logic        beat;
  logic        keep_ok;
  logic [31:0] w;

  // Single-cycle events decoded from the current beat.
  logic ev_short, ev_long, ev_keep, ev_good;

  // Shadow copy of beats 0..2. Beat 3 goes straight to the outputs.
  logic [31:0] sh_src_hi;
  logic [15:0] sh_src_lo;
  logic [15:0] sh_dst_hi;
  logic [31:0] sh_dst_lo;

  // Gated by rst so the stream is not accepted while reset is asserted.
  assign ready_slave  = ~rst & (state != HOLD);
  assign beat         = valid_slave & ready_slave;
  assign keep_ok      = (keep_slave == 4'hf);
  assign w            = {data_slave[7:0], data_slave[15:8],
                         data_slave[23:16], data_slave[31:24]};
  assign result_valid = (state == HOLD);

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    keep_bad_nxt = keep_bad;
    ev_short     = 1'b0;
    ev_long      = 1'b0;
    ev_keep      = 1'b0;
    ev_good      = 1'b0;
    unique case (state)
      COLLECT: begin
        if (beat) begin
          if (last_slave && idx != 2'd3) begin
            // A short frame wins over any keep problem.
            ev_short     = 1'b1;
            idx_nxt      = 2'd0;
            keep_bad_nxt = 1'b0;
          end else if (idx == 2'd3 && last_slave) begin
            idx_nxt      = 2'd0;
            keep_bad_nxt = 1'b0;
            if (keep_bad || !keep_ok) begin
              ev_keep = 1'b1;
            end else begin
              ev_good   = 1'b1;
              state_nxt = HOLD;
            end
          end else if (idx == 2'd3) begin
            // Long frame: the keep check is skipped. The rest is drained.
            ev_long      = 1'b1;
            idx_nxt      = 2'd0;
            keep_bad_nxt = 1'b0;
            state_nxt    = DRAIN;
          end else begin
            idx_nxt      = idx + 2'd1;
            keep_bad_nxt = keep_bad | ~keep_ok;
          end
        end
      end
      HOLD: begin
        if (result_ready) state_nxt = COLLECT;
      end
      DRAIN: begin
        if (beat && last_slave) begin
          state_nxt    = COLLECT;
          idx_nxt      = 2'd0;
          keep_bad_nxt = 1'b0;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      idx      <= 2'd0;
      keep_bad <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      keep_bad <= keep_bad_nxt;
    end
  end

  // NOTE: the field registers are reset as well, because a reset must clear
  // every visible field and no stale partial frame may survive it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_src_hi   <= '0;
      sh_src_lo   <= '0;
      sh_dst_hi   <= '0;
      sh_dst_lo   <= '0;
      src_address <= '0;
      dst_address <= '0;
      operation   <= 1'b0;
      counter     <= '0;
    end else begin
      if (state == COLLECT && beat) begin
        unique case (idx)
          2'd0: sh_src_hi <= w;
          2'd1: begin
            sh_src_lo <= w[31:16];
            sh_dst_hi <= w[15:0];
          end
          2'd2: sh_dst_lo <= w;
          default: ;
        endcase
      end
      if (ev_good) begin
        src_address <= {sh_src_hi, sh_src_lo};
        dst_address <= {sh_dst_hi, sh_dst_lo};
        operation   <= w[31];
        counter     <= w[30:0];
      end
    end
  end

  // Error pulses and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_keep    <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      err_short <= ev_short;
      err_long  <= ev_long;
      err_keep  <= ev_keep;
      if ((ev_short || ev_long || ev_keep) && err_count != '1)
        err_count <= err_count + 1'b1;
      if (state == HOLD && result_ready && frame_count != '1)
        frame_count <= frame_count + 1'b1;
    end
  end

`ifdef RDMA_SEQ_CHECK_EN
  logic        seq_seen;
  logic [30:0] last_counter;

  // Evaluated on the same edge that raises result_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_seen     <= 1'b0;
      last_counter <= '0;
      err_seq      <= 1'b0;
    end else begin
      err_seq <= 1'b0;
      if (ev_good) begin
        seq_seen     <= 1'b1;
        last_counter <= w[30:0];
        err_seq      <= seq_seen && (w[30:0] != last_counter + 31'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rdma_unpacker.sv
// ---------------------------------------------------------------------------
// tb_rdma_unpacker
//   Self-checking bench for rdma_unpacker. It runs directed frames from the
//   test plan, then random frames with random stalls and result back-pressure.
//   A frame-level reference model classifies each frame and predicts the
//   decoded header. Narrow counters are used so that saturation is reached.
// ---------------------------------------------------------------------------
module tb_rdma_unpacker;

  localparam int TB_CNT_W = 3;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  localparam int K_GOOD  = 0;
  localparam int K_SHORT = 1;
  localparam int K_LONG  = 2;
  localparam int K_KEEP  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         data_slave;
  logic [3:0]          keep_slave;
  logic                valid_slave;
  logic                last_slave;
  logic                ready_slave;
  logic [47:0]         src_address;
  logic [47:0]         dst_address;
  logic                operation;
  logic [30:0]         counter;
  logic                result_valid;
  logic                result_ready;
  logic                err_short;
  logic                err_long;
  logic                err_keep;
  logic [TB_CNT_W-1:0] frame_count;
  logic [TB_CNT_W-1:0] err_count;
`ifdef RDMA_SEQ_CHECK_EN
  logic                err_seq;
`endif

  rdma_unpacker #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_slave   (data_slave),
    .keep_slave   (keep_slave),
    .valid_slave  (valid_slave),
    .last_slave   (last_slave),
    .ready_slave  (ready_slave),
    .src_address  (src_address),
    .dst_address  (dst_address),
    .operation    (operation),
    .counter      (counter),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err_short    (err_short),
    .err_long     (err_long),
    .err_keep     (err_keep),
    .frame_count  (frame_count),
    .err_count    (err_count)
`ifdef RDMA_SEQ_CHECK_EN
    ,
    .err_seq      (err_seq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame under test (wire order) and the reference model state.
  logic [31:0] fd [8];
  logic [3:0]  fk [8];
  int          flen;

  logic [47:0] m_src, m_dst;
  logic        m_op;
  logic [30:0] m_ctr;
  int          exp_fc, exp_ec;
  logic        m_seq_seen;
  logic [30:0] m_last_ctr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte reversal of a 32-bit word (it is its own inverse).
  function automatic logic [31:0] brev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Frame classification from the frame rules. dec = beat (1-based) on
  // which the outcome becomes known.
  task automatic classify(output int kind, output int dec);
    if (flen < 4) begin
      kind = K_SHORT; dec = flen;
    end else if (flen > 4) begin
      kind = K_LONG; dec = 4;
    end else begin
      kind = K_GOOD; dec = 4;
      for (int i = 0; i < 4; i++) if (fk[i] != 4'hf) kind = K_KEEP;
    end
  endtask

  // Builds a legal frame that carries the given header.
  task automatic set_good(input logic [47:0] s, input logic [47:0] d,
                          input logic op, input logic [30:0] c);
    logic [127:0] hdr;
    hdr = {s, d, op, c};
    for (int i = 0; i < 4; i++) begin
      fd[i] = brev(hdr[127 - 32*i -: 32]);
      fk[i] = 4'hf;
    end
    flen = 4;
  endtask

  task automatic idle_inputs();
    valid_slave = 1'b0;
    data_slave  = $urandom;
    keep_slave  = 4'($urandom);
    last_slave  = 1'($urandom);
  endtask

  // Called at a negedge. It returns at the negedge after the handshake.
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic l, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      idle_inputs();
      @(negedge clk);
    end
    valid_slave = 1'b1;
    data_slave  = d;
    keep_slave  = k;
    last_slave  = l;
    guard = 0;
    while (!ready_slave && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("beat_timeout", 1'b0, 1'b1);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    result_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ready",  ready_slave,  1'b0);
    check("rst_rvalid", result_valid, 1'b0);
    check("rst_src",    src_address,  48'h0);
    check("rst_dst",    dst_address,  48'h0);
    check("rst_op",     operation,    1'b0);
    check("rst_ctr",    counter,      31'h0);
    check("rst_errs",   {err_short, err_long, err_keep}, 3'b000);
    check("rst_fc",     frame_count,  0);
    check("rst_ec",     err_count,    0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", ready_slave, 1'b1);
    m_src = '0; m_dst = '0; m_op = 1'b0; m_ctr = '0;
    exp_fc = 0; exp_ec = 0;
    m_seq_seen = 1'b0; m_last_ctr = '0;
    @(negedge clk);
  endtask

  // Sends the frame in fd/fk/flen and checks each beat against the model.
  // hold < 0 picks a random number of back-pressure cycles.
  task automatic run_frame(input int hold, input int max_gap);
    int          kind, dec, h;
    logic [127:0] hdr;
    logic        exp_seq;
    classify(kind, dec);
    for (int i = 1; i <= flen; i++) begin
      drive_beat(fd[i-1], fk[i-1], i == flen, $urandom_range(0, max_gap));
      exp_seq = 1'b0;
      if (kind == K_GOOD && i == 4) begin
        hdr = {brev(fd[0]), brev(fd[1]), brev(fd[2]), brev(fd[3])};
        m_src = hdr[127:80];
        m_dst = hdr[79:32];
        m_op  = hdr[31];
        m_ctr = hdr[30:0];
        exp_seq = m_seq_seen && (m_ctr != m_last_ctr + 31'd1);
        m_seq_seen = 1'b1;
        m_last_ctr = m_ctr;
      end
      if (kind != K_GOOD && i == dec) exp_ec = sat_inc(exp_ec);
      check("err_short",    err_short,    kind == K_SHORT && i == dec);
      check("err_long",     err_long,     kind == K_LONG  && i == dec);
      check("err_keep",     err_keep,     kind == K_KEEP  && i == dec);
      check("result_valid", result_valid, kind == K_GOOD  && i == 4);
`ifdef RDMA_SEQ_CHECK_EN
      check("err_seq",      err_seq,      exp_seq);
`endif
    end
    if (kind == K_GOOD) begin
      check("src_address", src_address, m_src);
      check("dst_address", dst_address, m_dst);
      check("operation",   operation,   m_op);
      check("counter",     counter,     m_ctr);
      h = (hold < 0) ? $urandom_range(0, 4) : hold;
      for (int c = 0; c < h; c++) begin
        check("hold_rvalid", result_valid, 1'b1);
        check("hold_ready",  ready_slave,  1'b0);
        check("hold_ctr",    counter,      m_ctr);
        @(negedge clk);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      exp_fc = sat_inc(exp_fc);
      check("post_rvalid", result_valid, 1'b0);
      check("post_ready",  ready_slave,  1'b1);
    end
    check("frame_count", frame_count, exp_fc);
    check("err_count",   err_count,   exp_ec);
    check("src_keep",    src_address, m_src);
    check("dst_keep",    dst_address, m_dst);
  endtask

  initial begin
    rst = 1'b1;
    result_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Test-plan frame, immediate acceptance.
    fd[0] = 32'h33221100; fd[1] = 32'h77665544;
    fd[2] = 32'hBBAA9988; fd[3] = 32'h78563492;
    for (int i = 0; i < 4; i++) fk[i] = 4'hf;
    flen = 4;
    run_frame(0, 0);
    check("plan_src", src_address, 48'h001122334455);
    check("plan_ctr", counter,     31'h12345678);

    // Same frame held for 5 cycles.
    run_frame(5, 1);

    // Short frame, followed by a good frame.
    flen = 2;
    run_frame(0, 1);
    set_good(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1'b0, 31'h0000_0042);
    run_frame(-1, 1);

    // Long frame (6 beats), followed by a good frame.
    flen = 6;
    for (int i = 0; i < 6; i++) begin fd[i] = $urandom; fk[i] = 4'hf; end
    run_frame(0, 1);
    set_good(48'h0102030405AB, 48'hCAFEF00DBEEF, 1'b1, 31'h7FFF_FFFF);
    run_frame(-1, 1);

    // Partial keep on beat 2.
    set_good(48'h111111111111, 48'h222222222222, 1'b0, 31'h3);
    fk[1] = 4'h7;
    run_frame(0, 1);

    // Reset in the middle of a frame, then a clean frame.
    drive_beat(32'hDEADBEEF, 4'hf, 1'b0, 0);
    drive_beat(32'h01234567, 4'h7, 1'b0, 0);
    do_reset();
    set_good(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 1'b1, 31'h1234);
    run_frame(-1, 1);

    // Sequence: counters 5, 6, 8.
    set_good(48'h1, 48'h2, 1'b0, 31'd5); run_frame(0, 0);
    set_good(48'h1, 48'h2, 1'b0, 31'd6); run_frame(0, 0);
    set_good(48'h1, 48'h2, 1'b0, 31'd8); run_frame(0, 0);

    // Random frames: lengths, keeps, stalls, back-pressure and saturation.
    for (int f = 0; f < 60; f++) begin
      flen = ($urandom_range(0, 9) < 6) ? 4 : $urandom_range(1, 6);
      for (int i = 0; i < flen; i++) begin
        fd[i] = $urandom;
        fk[i] = 4'hf;
        if ($urandom_range(0, 7) == 0) begin
          fk[i] = 4'($urandom);
          if (fk[i] == 4'hf) fk[i] = 4'h7;
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        // Consecutive counter, so that the in-sequence case also occurs.
        set_good(48'($urandom) << 16, 48'($urandom), 1'($urandom), m_ctr + 31'd1);
      end
      run_frame(-1, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
